// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: ALU control-bit weights, op codes, FSM encodings shared by the sequencer and decoder.
package alu_sequencer_pkg;
   localparam logic [5:0] EX = 6'd32, NX = 6'd16, EY = 6'd8, NY = 6'd4, F = 6'd2, NO = 6'd1;
   localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_RSUB = 5'd2, OP_AND = 5'd3, OP_OR = 5'd4;
   localparam logic [4:0] OP_ZERO = 5'd5, OP_ONE = 5'd6, OP_NEG1 = 5'd7, OP_X = 5'd8, OP_Y = 5'd9;
   localparam logic [4:0] OP_NOTX = 5'd10, OP_NOTY = 5'd11, OP_NEGX = 5'd12, OP_NEGY = 5'd13;
   localparam logic [4:0] OP_INCX = 5'd14, OP_INCY = 5'd15, OP_DECX = 5'd16, OP_DECY = 5'd17;
   localparam logic [4:0] OP_SHL = 5'd18, OP_MUL = 5'd19, OP_LAST_LEGAL = 5'd19;
   localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3;

   function automatic logic [5:0] mul_step_ctrl(input logic add);
      return add ? (EX | EY | F) : (EX | F);
   endfunction
endpackage

// File: rtl/alu_opdecode.sv
// alu_opdecode: maps an op code to the ALU control word and MUL/SHL/illegal classification.
module alu_opdecode
   import alu_sequencer_pkg::*;
(
   input  logic [4:0] op,
   output logic [5:0] ctrl,
   output logic       is_mul,
   output logic       is_shl,
   output logic       illegal
);
   always_comb begin
      is_mul  = op == OP_MUL;
      is_shl  = op == OP_SHL;
      illegal = op > OP_LAST_LEGAL;
      case (op)
         OP_ADD, OP_SHL: ctrl = EX | EY | F;
         OP_SUB:         ctrl = EX | EY | NX | F | NO;
         OP_RSUB:        ctrl = EX | EY | NY | F | NO;
         OP_AND:         ctrl = EX | EY;
         OP_OR:          ctrl = EX | EY | NX | NY | NO;
         OP_ONE:         ctrl = NX | NY | F | NO;
         OP_NEG1:        ctrl = NX | NY;
         OP_X:           ctrl = EX | F;
         OP_Y:           ctrl = EY | F;
         OP_NOTX:        ctrl = EX | NX | F;
         OP_NOTY:        ctrl = EY | NY | F;
         OP_NEGX:        ctrl = EX | NY | F | NO;
         OP_NEGY:        ctrl = EY | NX | F | NO;
         OP_INCX:        ctrl = EX | NX | NY | F | NO;
         OP_INCY:        ctrl = EY | NX | NY | F | NO;
         OP_DECX:        ctrl = EX | NY | F;
         OP_DECY:        ctrl = EY | NX | F;
         default:        ctrl = F;
      endcase
   end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: handshaked front end for the combinational ALU; runs single ops and a shift-add MUL.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MUL_STEPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             err,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_c,
   input  logic [WIDTH-1:0] alu_out
);
   localparam int CW = $clog2(MUL_STEPS);
   localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

   logic [1:0]       state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             zero_q, zero_d, neg_q, neg_d, err_q, err_d;
   logic [5:0]       dec_ctrl;
   logic             dec_mul, dec_shl, dec_ill;

   // In IDLE decode the incoming op; afterwards decode the latched one.
   alu_opdecode u_dec (
      .op      (state_q == S_IDLE ? op : op_q),
      .ctrl    (dec_ctrl),
      .is_mul  (dec_mul),
      .is_shl  (dec_shl),
      .illegal (dec_ill)
   );

   assign op_ready  = state_q == S_IDLE;
   assign res_valid = state_q == S_DONE;
   assign result    = result_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign err       = err_q;
   // During MUL, a_q holds the shifting multiplicand and b_q the multiplier.
   assign alu_x = state_q == S_EXEC ? a_q : state_q == S_MUL ? acc_q : '0;
   assign alu_y = state_q == S_EXEC ? b_q : state_q == S_MUL ? a_q : '0;
   assign alu_c = state_q == S_EXEC ? dec_ctrl : state_q == S_MUL ? mul_step_ctrl(b_q[0]) : F;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: if (op_valid) begin
            op_d    = op;
            a_d     = a;
            b_d     = dec_shl ? a : b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = dec_ill ? S_DONE : dec_mul ? S_MUL : S_EXEC;
            if (dec_ill) begin
               result_d = '0;
               zero_d   = 1'b1;
               neg_d    = 1'b0;
               err_d    = 1'b1;
            end
         end
         S_MUL: begin
            acc_d = alu_out;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
         end
         S_DONE: state_d = res_ready ? S_IDLE : S_DONE;
         default: ;
      endcase
      if (state_q == S_EXEC || (state_q == S_MUL && cnt_q == LAST)) begin
         result_d = alu_out;
         zero_d   = alu_out == '0;
         neg_d    = alu_out[WIDTH-1];
         err_d    = 1'b0;
         state_d  = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against alu_sequencer driving a behavioural ALU.
module tb_alu_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        op_valid = 1'b0, op_ready, res_valid, res_ready = 1'b0;
   logic [4:0]  op = '0;
   logic [15:0] a = '0, b = '0, result, alu_x, alu_y, alu_out;
   logic        zero, neg, err;
   logic [5:0]  alu_c;
   int          n_vec = 0, n_err = 0, lat;
   logic [5:0]  first_c;
   logic [15:0] held;

   alu_sequencer #(.WIDTH(16), .MUL_STEPS(16)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op), .a(a), .b(b),
      .res_valid(res_valid), .res_ready(res_ready), .result(result), .zero(zero), .neg(neg), .err(err),
      .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_out(alu_out)
   );

   function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
      logic [15:0] xx, yy, o;
      xx = c[5] ? x : 16'h0;
      xx = c[4] ? ~xx : xx;
      yy = c[3] ? y : 16'h0;
      yy = c[2] ? ~yy : yy;
      o  = c[1] ? xx + yy : xx & yy;
      return c[0] ? ~o : o;
   endfunction

   assign alu_out = alu_f(alu_x, alu_y, alu_c);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one op and counts edges, accept edge included, until res_valid rises.
   task automatic run_op(input logic [4:0] o, input logic [15:0] av, input logic [15:0] bv,
                         output int edges, output logic [5:0] c1);
      @(negedge clk);
      op = o; a = av; b = bv; op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; op = 5'd1;
      edges = 1;
      c1 = alu_c;
      while (!res_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic take();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("op_ready_after_take", op_ready, 1);
   endtask

   initial begin
      #12;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_alu_c", alu_c, 6'h02);
      chk("rst_alu_x", alu_x, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rst_op_ready", op_ready, 1);

      run_op(5'd0, 16'h1234, 16'h0FFF, lat, first_c);
      chk("add_lat", lat, 2);
      chk("add_exec_c", first_c, 6'h2A);
      chk("add_result", result, 16'h2233);
      chk("add_zero", zero, 0);
      chk("add_neg", neg, 0);
      held = result;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_result", result, held);
         chk("bp_op_ready", op_ready, 0);
         chk("bp_res_valid", res_valid, 1);
      end
      take();

      run_op(5'd1, 16'd3, 16'd5, lat, first_c);
      chk("sub_result", result, 16'hFFFE);
      chk("sub_neg", neg, 1);
      take();
      run_op(5'd16, 16'd0, 16'd9, lat, first_c);
      chk("decx_result", result, 16'hFFFF);
      take();
      run_op(5'd5, 16'h5555, 16'hAAAA, lat, first_c);
      chk("zero_result", result, 0);
      chk("zero_flag", zero, 1);
      take();
      run_op(5'd4, 16'h00F0, 16'h0F00, lat, first_c);
      chk("or_result", result, 16'h0FF0);
      take();
      run_op(5'd6, 16'h1234, 16'h4321, lat, first_c);
      chk("one_result", result, 16'h0001);
      take();

      run_op(5'd19, 16'd300, 16'd7, lat, first_c);
      chk("mul_lat", lat, 17);
      chk("mul_result", result, 16'h0834);
      chk("mul_zero", zero, 0);
      take();
      run_op(5'd19, 16'h0100, 16'h0100, lat, first_c);
      chk("mulwrap_result", result, 0);
      chk("mulwrap_zero", zero, 1);
      take();
      run_op(5'd19, 16'hFFFF, 16'hFFFF, lat, first_c);
      chk("mulneg_result", result, 16'h0001);
      take();

      run_op(5'd25, 16'h1111, 16'h2222, lat, first_c);
      chk("ill_lat", lat, 1);
      chk("ill_err", err, 1);
      chk("ill_result", result, 0);
      chk("ill_zero", zero, 1);
      chk("ill_alu_c", alu_c, 6'h02);
      take();
      run_op(5'd18, 16'h8001, 16'h7777, lat, first_c);
      chk("shl_result", result, 16'h0002);
      chk("shl_err", err, 0);
      chk("shl_lat", lat, 2);
      take();

      @(negedge clk);
      op = 5'd19; a = 16'd300; b = 16'd7; op_valid = 1'b1;
      @(posedge clk); #1 op_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_res_valid", res_valid, 0);
      chk("mrst_result", result, 0);
      chk("mrst_err", err, 0);
      chk("mrst_alu_c", alu_c, 6'h02);
      chk("mrst_alu_x", alu_x, 0);
      chk("mrst_alu_y", alu_y, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("mrst_op_ready", op_ready, 1);
      run_op(5'd0, 16'd1, 16'd1, lat, first_c);
      chk("post_rst_add", result, 16'd2);
      chk("post_rst_lat", lat, 2);
      take();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
